// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pixel output stage: FSM states, the
// RGB565 pixel layout and the RGB565 -> 3x10-bit colour expansion.
package vga_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    ARMED   = 2'd1,
    STREAM  = 2'd2,
    STARVED = 2'd3
  } vga_state_t;

  typedef enum logic [1:0] {
    PIX_BLACK = 2'd0,
    PIX_DATA  = 2'd1,
    PIX_UF    = 2'd2
  } pix_src_t;

  typedef struct packed {
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
  } rgb565_t;

  // Bit replication keeps full white at 10'h3FF and black at 10'h000.
  function automatic logic [29:0] rgb565_to_rgb30(input rgb565_t c);
    rgb565_to_rgb30 = {c.r5, c.r5, c.g6, c.g6[5:2], c.b5, c.b5};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; reset loads every stage with an idle pattern so
// the delayed signals come out inactive until real samples have propagated.
module vga_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift samples toward the output, flushing to INIT on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= INIT;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_pixel_out.sv
// Pops RGB565 pixels from a FIFO in step with raw VGA timing and drives
// registered 10-bit colour plus matching syncs two cycles later.
module vga_pixel_out #(
  parameter int          HDISP    = 640,
  parameter int          VDISP    = 480,
  parameter logic [15:0] UF_COLOR = 16'hF800
) (
  input  logic        VGA_CLK,
  input  logic        RST,
  input  logic        HS_IN,
  input  logic        VS_IN,
  input  logic        DE_IN,
  input  logic [15:0] FIFO_RDATA,
  input  logic        FIFO_REMPTY,
  output logic        FIFO_READ,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic        UNDERFLOW,
  output logic        RESYNC,
  output logic        FRAME_ERR
);

  import vga_pkg::*;

  localparam int             N_PIX   = HDISP * VDISP;
  localparam int             CW      = $clog2(N_PIX + 1);
  localparam logic [CW-1:0]  N_PIX_C = CW'(N_PIX);

  vga_state_t    state_r, state_s;
  pix_src_t      src_r, src_s;
  logic          vs_prev_r;
  logic          vs_fall_s, vs_rise_s, frame_end_s;
  logic          fifo_read_s, starve_s;
  logic [CW-1:0] cnt_r;
  logic [29:0]   rgb_r;
  logic          underflow_r, resync_r, frame_err_r;
  logic [2:0]    tim_q;

  assign vs_fall_s   = vs_prev_r & ~VS_IN;
  assign vs_rise_s   = ~vs_prev_r & VS_IN;
  assign frame_end_s = vs_fall_s & ((state_r == STREAM) | (state_r == STARVED));

  // Next state, FIFO pop and per-pixel colour source; a VS falling edge wins over starvation.
  always_comb begin
    state_s     = state_r;
    fifo_read_s = 1'b0;
    starve_s    = 1'b0;
    src_s       = PIX_BLACK;
    case (state_r)
      SYNC: begin
        if (vs_rise_s && !FIFO_REMPTY) state_s = ARMED;
        else                           state_s = SYNC;
      end
      ARMED: begin
        fifo_read_s = DE_IN & ~FIFO_REMPTY & ~RST;
        if (DE_IN) state_s = STREAM;
        else       state_s = ARMED;
      end
      STREAM: begin
        fifo_read_s = DE_IN & ~FIFO_REMPTY & ~RST;
        if (vs_fall_s) begin
          state_s = ARMED;
        end else if (DE_IN && FIFO_REMPTY) begin
          starve_s = 1'b1;
          state_s  = STARVED;
        end else begin
          state_s = STREAM;
        end
      end
      STARVED: begin
        if (vs_fall_s) state_s = SYNC;
        else           state_s = STARVED;
      end
      default: state_s = SYNC;
    endcase
    if (RST || state_r == SYNC || !DE_IN) src_s = PIX_BLACK;
    else if (fifo_read_s)                 src_s = PIX_DATA;
    else if (state_r == STARVED || starve_s) src_s = PIX_UF;
    else                                  src_s = PIX_BLACK;
  end

  assign FIFO_READ = fifo_read_s;

  // State, frame accounting and the colour stage that waits one cycle for FIFO data.
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      state_r     <= SYNC;
      vs_prev_r   <= 1'b1;
      src_r       <= PIX_BLACK;
      rgb_r       <= 30'd0;
      cnt_r       <= '0;
      underflow_r <= 1'b0;
      resync_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      vs_prev_r   <= VS_IN;
      src_r       <= src_s;
      underflow_r <= underflow_r | starve_s;
      resync_r    <= vs_fall_s & (state_r == STARVED);
      frame_err_r <= frame_end_s & (cnt_r != N_PIX_C);
      case (src_r)
        PIX_DATA: rgb_r <= rgb565_to_rgb30(rgb565_t'(FIFO_RDATA));
        PIX_UF:   rgb_r <= rgb565_to_rgb30(rgb565_t'(UF_COLOR));
        default:  rgb_r <= 30'd0;
      endcase
      if (state_r == SYNC || frame_end_s) cnt_r <= '0;
      else if (fifo_read_s && cnt_r != N_PIX_C) cnt_r <= cnt_r + CW'(1);
      else cnt_r <= cnt_r;
    end
  end

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (2),
    .INIT  (3'b110)
  ) u_timing_dly (
    .clk  (VGA_CLK),
    .rst  (RST),
    .din  ({HS_IN, VS_IN, DE_IN}),
    .dout (tim_q)
  );

  assign VGA_HS    = tim_q[2];
  assign VGA_VS    = tim_q[1];
  assign VGA_BLANK = tim_q[0];
  assign VGA_R     = rgb_r[29:20];
  assign VGA_G     = rgb_r[19:10];
  assign VGA_B     = rgb_r[9:0];
  assign UNDERFLOW = underflow_r;
  assign RESYNC    = resync_r;
  assign FRAME_ERR = frame_err_r;

endmodule
